// File: rtl/rrf_pkg.sv
// Shared widths, zero constants and index/tag types for the rename register file.
package rrf_pkg;

  localparam int unsigned XLEN_D    = 32;
  localparam int unsigned NREG_D    = 32;
  localparam int unsigned ROB_W_D   = 4;
  localparam int unsigned DSP_W_D   = 2;
  localparam int unsigned CMT_W_D   = 2;
  localparam int unsigned NCKPT_D   = 4;
  localparam int unsigned REG_POS_W = 5;
  localparam int unsigned CKPT_ID_W = $clog2(NCKPT_D);

  typedef logic [REG_POS_W-1:0] reg_idx_t;
  typedef logic [ROB_W_D-1:0]   rob_tag_t;
  typedef logic [XLEN_D-1:0]    word_t;
  typedef logic [CKPT_ID_W-1:0] ckpt_id_t;

  localparam reg_idx_t ZERO_REG  = '0;
  localparam rob_tag_t ZERO_ROB  = '0;
  localparam word_t    ZERO_WORD = '0;

endpackage

// File: rtl/rrf_ckpt_bank.sv
// Circular bank of Q-table snapshots with head/tail/count bookkeeping.
// Commits clear matching tags inside stored snapshots every cycle.
module rrf_ckpt_bank
  import rrf_pkg::*;
#(
  parameter int unsigned NREG  = NREG_D,
  parameter int unsigned ROB_W = ROB_W_D,
  parameter int unsigned CMT_W = CMT_W_D,
  parameter int unsigned NCKPT = NCKPT_D
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CMT_W-1:0]                    i_cmt_en,
  input  logic [CMT_W-1:0][REG_POS_W-1:0]     i_cmt_rd,
  input  logic [CMT_W-1:0][ROB_W-1:0]         i_cmt_tag,
  input  logic                                i_flush,
  input  logic                                i_take,
  input  logic                                i_rel,
  input  logic                                i_recover,
  input  logic [$clog2(NCKPT)-1:0]            i_recover_id,
  input  logic [NREG-1:0][ROB_W-1:0]          i_snap_q,
  output logic [NREG-1:0][ROB_W-1:0]          o_rec_q_c,
  output logic [$clog2(NCKPT)-1:0]            o_id,
  output logic                                o_full
);

  localparam int unsigned ID_W  = $clog2(NCKPT);
  localparam int unsigned CNT_W = ID_W + 1;

  logic [NREG-1:0][ROB_W-1:0] r_slot [NCKPT];
  logic [ID_W-1:0]            r_head;
  logic [ID_W-1:0]            r_tail;
  logic [CNT_W-1:0]           r_count;
  logic                       r_full;

  logic [NREG-1:0][ROB_W-1:0] w_slot_cc [NCKPT];
  logic                       w_rel;
  logic                       w_take;
  logic [ID_W-1:0]            w_head_nxt;
  logic [ID_W-1:0]            w_tail_nxt;
  logic [CNT_W-1:0]           w_cnt_rel;
  logic [CNT_W-1:0]           w_count_nxt;

  // Clearing dead slots too is harmless: a take overwrites the whole slot.
  always_comb begin
    for (int k = 0; k < int'(NCKPT); k++) begin
      w_slot_cc[k] = r_slot[k];
      for (int c = 0; c < int'(CMT_W); c++) begin
        if (i_cmt_en[c] && (i_cmt_rd[c] != ZERO_REG) &&
            (r_slot[k][i_cmt_rd[c]] == i_cmt_tag[c])) begin
          w_slot_cc[k][i_cmt_rd[c]] = '0;
        end
      end
    end
    o_rec_q_c = w_slot_cc[i_recover_id];
  end

  // Release is applied before recover so the recount uses the new head.
  always_comb begin
    w_rel       = i_rel && (r_count != '0);
    w_head_nxt  = r_head + ID_W'(w_rel);
    w_cnt_rel   = r_count - CNT_W'(w_rel);
    w_take      = i_take && !r_full && !i_flush && !i_recover;
    w_tail_nxt  = r_tail;
    w_count_nxt = w_cnt_rel;
    if (i_flush) begin
      w_head_nxt  = r_tail;
      w_count_nxt = '0;
    end else if (i_recover) begin
      w_tail_nxt  = i_recover_id;
      w_count_nxt = CNT_W'(ID_W'(i_recover_id - w_head_nxt));
    end else if (w_take) begin
      w_tail_nxt  = r_tail + ID_W'(1);
      w_count_nxt = w_cnt_rel + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      for (int k = 0; k < int'(NCKPT); k++) r_slot[k] <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(NCKPT));
      for (int k = 0; k < int'(NCKPT); k++) r_slot[k] <= w_slot_cc[k];
      if (w_take) r_slot[r_tail] <= i_snap_q;
    end
  end

  assign o_id   = r_tail;
  assign o_full = r_full;

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file plus rename-tag table with dispatch bypass,
// ROB commit and single-cycle checkpoint recovery.
module rename_reg_file
  import rrf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_D,
  parameter int unsigned NREG  = NREG_D,
  parameter int unsigned ROB_W = ROB_W_D,
  parameter int unsigned DSP_W = DSP_W_D,
  parameter int unsigned CMT_W = CMT_W_D,
  parameter int unsigned NCKPT = NCKPT_D,
  localparam int unsigned LANE_W = (DSP_W > 1) ? $clog2(DSP_W) : 1,
  localparam int unsigned CKPT_W = $clog2(NCKPT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DSP_W-1:0][REG_POS_W-1:0]   rs1_i,
  input  logic [DSP_W-1:0][REG_POS_W-1:0]   rs2_i,
  output logic [DSP_W-1:0][XLEN-1:0]        v1_o,
  output logic [DSP_W-1:0][XLEN-1:0]        v2_o,
  output logic [DSP_W-1:0][ROB_W-1:0]       q1_o,
  output logic [DSP_W-1:0][ROB_W-1:0]       q2_o,
  input  logic [DSP_W-1:0]                  dsp_en_i,
  input  logic [DSP_W-1:0][REG_POS_W-1:0]   dsp_rd_i,
  input  logic [DSP_W-1:0][ROB_W-1:0]       dsp_tag_i,
  input  logic [CMT_W-1:0]                  cmt_en_i,
  input  logic [CMT_W-1:0][REG_POS_W-1:0]   cmt_rd_i,
  input  logic [CMT_W-1:0][ROB_W-1:0]       cmt_tag_i,
  input  logic [CMT_W-1:0][XLEN-1:0]        cmt_val_i,
  input  logic                              flush_i,
  input  logic                              ckpt_take_i,
  input  logic [LANE_W-1:0]                 ckpt_lane_i,
  output logic [CKPT_W-1:0]                 ckpt_id_o,
  output logic                              ckpt_full_o,
  input  logic                              ckpt_rel_i,
  input  logic                              recover_i,
  input  logic [CKPT_W-1:0]                 recover_id_i
);

  logic [NREG-1:0][ROB_W-1:0]       r_q;
  logic [NREG-1:0][XLEN-1:0]        r_v;

  logic [2*DSP_W-1:0][REG_POS_W-1:0] w_rs;
  logic [2*DSP_W-1:0][ROB_W-1:0]     w_rq;
  logic [2*DSP_W-1:0][XLEN-1:0]      w_rv;
  logic [NREG-1:0][ROB_W-1:0]        w_q_cc;
  logic [NREG-1:0][ROB_W-1:0]        w_q_alloc;
  logic [NREG-1:0][ROB_W-1:0]        w_q_snap;
  logic [NREG-1:0][ROB_W-1:0]        w_rec_q;

  // Read ports: rs1 of every lane occupy slots 0..DSP_W-1, rs2 the upper half.
  always_comb begin
    w_rs = '0;
    w_rq = '0;
    w_rv = '0;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < int'(DSP_W); j++) begin
        w_rs[s*DSP_W+j] = (s == 0) ? rs1_i[j] : rs2_i[j];
        w_rq[s*DSP_W+j] = r_q[w_rs[s*DSP_W+j]];
        w_rv[s*DSP_W+j] = r_v[w_rs[s*DSP_W+j]];
        for (int c = 0; c < int'(CMT_W); c++) begin
          if (cmt_en_i[c] && (cmt_rd_i[c] == w_rs[s*DSP_W+j])) begin
            w_rv[s*DSP_W+j] = cmt_val_i[c];
            if (cmt_tag_i[c] == r_q[w_rs[s*DSP_W+j]]) w_rq[s*DSP_W+j] = '0;
          end
        end
        // Older lanes only; the ascending loop leaves the youngest match.
        for (int i = 0; i < int'(DSP_W); i++) begin
          if ((i < j) && dsp_en_i[i] && (dsp_rd_i[i] == w_rs[s*DSP_W+j])) begin
            w_rq[s*DSP_W+j] = dsp_tag_i[i];
          end
        end
        if (w_rs[s*DSP_W+j] == ZERO_REG) begin
          w_rq[s*DSP_W+j] = ROB_W'(ZERO_ROB);
          w_rv[s*DSP_W+j] = XLEN'(ZERO_WORD);
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < int'(DSP_W); j++) begin
      q1_o[j] = w_rq[j];
      v1_o[j] = w_rv[j];
      q2_o[j] = w_rq[DSP_W+j];
      v2_o[j] = w_rv[DSP_W+j];
    end
  end

  // Next Q: commit-clears first, then allocs (younger lane wins).
  always_comb begin
    w_q_cc = r_q;
    for (int c = 0; c < int'(CMT_W); c++) begin
      if (cmt_en_i[c] && (cmt_rd_i[c] != ZERO_REG) &&
          (r_q[cmt_rd_i[c]] == cmt_tag_i[c])) begin
        w_q_cc[cmt_rd_i[c]] = '0;
      end
    end
    w_q_alloc = w_q_cc;
    w_q_snap  = w_q_cc;
    for (int i = 0; i < int'(DSP_W); i++) begin
      if (dsp_en_i[i] && (dsp_rd_i[i] != ZERO_REG)) begin
        w_q_alloc[dsp_rd_i[i]] = dsp_tag_i[i];
        if (LANE_W'(i) <= ckpt_lane_i) w_q_snap[dsp_rd_i[i]] = dsp_tag_i[i];
      end
    end
  end

  rrf_ckpt_bank #(
    .NREG  (NREG),
    .ROB_W (ROB_W),
    .CMT_W (CMT_W),
    .NCKPT (NCKPT)
  ) u_ckpt (
    .clk          (clk),
    .rst          (rst),
    .i_cmt_en     (cmt_en_i),
    .i_cmt_rd     (cmt_rd_i),
    .i_cmt_tag    (cmt_tag_i),
    .i_flush      (flush_i),
    .i_take       (ckpt_take_i),
    .i_rel        (ckpt_rel_i),
    .i_recover    (recover_i),
    .i_recover_id (recover_id_i),
    .i_snap_q     (w_q_snap),
    .o_rec_q_c    (w_rec_q),
    .o_id         (ckpt_id_o),
    .o_full       (ckpt_full_o)
  );

  // Value commits land even during flush or recover.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      r_v <= '0;
    end else begin
      if (flush_i)        r_q <= '0;
      else if (recover_i) r_q <= w_rec_q;
      else                r_q <= w_q_alloc;
      for (int c = 0; c < int'(CMT_W); c++) begin
        if (cmt_en_i[c] && (cmt_rd_i[c] != ZERO_REG)) r_v[cmt_rd_i[c]] <= cmt_val_i[c];
      end
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench: per-cycle read/bypass/commit vector table plus checkpoint sequences.
module tb_rename_reg_file;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ROB_W = 4;
  localparam int unsigned DSP_W = 2;
  localparam int unsigned CMT_W = 2;
  localparam int NV = 10;

  logic clk;
  logic rst;
  logic [DSP_W-1:0][4:0]       rs1_i, rs2_i;
  logic [DSP_W-1:0][XLEN-1:0]  v1_o, v2_o;
  logic [DSP_W-1:0][ROB_W-1:0] q1_o, q2_o;
  logic [DSP_W-1:0]            dsp_en_i;
  logic [DSP_W-1:0][4:0]       dsp_rd_i;
  logic [DSP_W-1:0][ROB_W-1:0] dsp_tag_i;
  logic [CMT_W-1:0]            cmt_en_i;
  logic [CMT_W-1:0][4:0]       cmt_rd_i;
  logic [CMT_W-1:0][ROB_W-1:0] cmt_tag_i;
  logic [CMT_W-1:0][XLEN-1:0]  cmt_val_i;
  logic flush_i, ckpt_take_i, ckpt_full_o, ckpt_rel_i, recover_i;
  logic [0:0] ckpt_lane_i;
  logic [1:0] ckpt_id_o, recover_id_i;

  int total = 0;
  int bad = 0;

  rename_reg_file dut (
    .clk(clk), .rst(rst),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .v1_o(v1_o), .v2_o(v2_o), .q1_o(q1_o), .q2_o(q2_o),
    .dsp_en_i(dsp_en_i), .dsp_rd_i(dsp_rd_i), .dsp_tag_i(dsp_tag_i),
    .cmt_en_i(cmt_en_i), .cmt_rd_i(cmt_rd_i), .cmt_tag_i(cmt_tag_i), .cmt_val_i(cmt_val_i),
    .flush_i(flush_i), .ckpt_take_i(ckpt_take_i), .ckpt_lane_i(ckpt_lane_i),
    .ckpt_id_o(ckpt_id_o), .ckpt_full_o(ckpt_full_o), .ckpt_rel_i(ckpt_rel_i),
    .recover_i(recover_i), .recover_id_i(recover_id_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] den, drd0, dtag0, drd1, dtag1;
    logic [31:0] cen, crd0, ctag0, cval0, crd1, ctag1, cval1;
    logic [31:0] rs1_0, rs1_1, rs2_1;
    logic [31:0] eq1_0, ev1_0, eq1_1, ev1_1, eq2_1, ev2_1;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rs1_i = '0; rs2_i = '0;
    dsp_en_i = '0; dsp_rd_i = '0; dsp_tag_i = '0;
    cmt_en_i = '0; cmt_rd_i = '0; cmt_tag_i = '0; cmt_val_i = '0;
    flush_i = 0; ckpt_take_i = 0; ckpt_lane_i = '0; ckpt_rel_i = 0;
    recover_i = 0; recover_id_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] r, input logic [31:0] eq,
                        input logic [31:0] ev);
    rs1_i[0] = r;
    #1;
    chk({nm, " q"}, 32'(q1_o[0]), eq);
    chk({nm, " v"}, v1_o[0], ev);
  endtask

  task automatic take_fill(input string nm);
    for (int k = 0; k < 4; k++) begin
      idle(); ckpt_take_i = 1; tick();
      idle(); chk($sformatf("%s full after take %0d", nm, k + 1), 32'(ckpt_full_o),
                  (k == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    //            den drd0 dt0 drd1 dt1 cen crd0 ct0 cval0 crd1 ct1 cval1 rs1_0 rs1_1 rs2_1 eq1_0 ev1_0 eq1_1 ev1_1 eq2_1 ev2_1
    vecs[0] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,     0, 0, 0,     5,  0,  5,  0, 0,     0, 0,     0, 0};
    vecs[1] = '{1, 3, 4, 0, 0,  0, 0, 0, 0,     0, 0, 0,     3,  3,  5,  0, 0,     4, 0,     0, 0};
    vecs[2] = '{1, 7, 2, 0, 0,  0, 0, 0, 0,     0, 0, 0,     3,  3,  0,  4, 0,     4, 0,     0, 0};
    vecs[3] = '{0, 0, 0, 0, 0,  1, 7, 2, 'hAB,  0, 0, 0,     7,  7,  3,  0, 'hAB,  0, 'hAB,  4, 0};
    vecs[4] = '{2, 0, 0, 7, 2,  0, 0, 0, 0,     0, 0, 0,     7,  7,  9,  0, 'hAB,  0, 'hAB,  0, 0};
    vecs[5] = '{1, 7, 6, 0, 0,  1, 7, 2, 'h11,  0, 0, 0,     7,  7,  3,  0, 'h11,  6, 'h11,  4, 0};
    vecs[6] = '{0, 0, 0, 0, 0,  3, 9, 1, 'h22,  9, 1, 'h33,  7,  7,  9,  6, 'h11,  6, 'h11,  0, 'h33};
    vecs[7] = '{3, 10, 7, 10, 8, 0, 0, 0, 0,    0, 0, 0,     9,  10, 9,  0, 'h33,  7, 0,     0, 'h33};
    vecs[8] = '{1, 0, 9, 0, 0,  2, 0, 0, 0,     0, 0, 'h55,  10, 0,  10, 8, 0,     0, 0,     8, 0};
    vecs[9] = '{0, 0, 0, 0, 0,  1, 3, 6, 'h44,  0, 0, 0,     10, 7,  3,  8, 0,     6, 'h11,  4, 'h44};

    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("reset full", 32'(ckpt_full_o), 0);
    chk("reset id", 32'(ckpt_id_o), 0);

    for (int k = 0; k < NV; k++) begin
      idle();
      dsp_en_i     = 2'(vecs[k].den);
      dsp_rd_i[0]  = 5'(vecs[k].drd0);  dsp_tag_i[0] = 4'(vecs[k].dtag0);
      dsp_rd_i[1]  = 5'(vecs[k].drd1);  dsp_tag_i[1] = 4'(vecs[k].dtag1);
      cmt_en_i     = 2'(vecs[k].cen);
      cmt_rd_i[0]  = 5'(vecs[k].crd0);  cmt_tag_i[0] = 4'(vecs[k].ctag0);
      cmt_val_i[0] = vecs[k].cval0;
      cmt_rd_i[1]  = 5'(vecs[k].crd1);  cmt_tag_i[1] = 4'(vecs[k].ctag1);
      cmt_val_i[1] = vecs[k].cval1;
      rs1_i[0] = 5'(vecs[k].rs1_0);
      rs1_i[1] = 5'(vecs[k].rs1_1);
      rs2_i[1] = 5'(vecs[k].rs2_1);
      #1;
      chk($sformatf("vec%0d q1_0", k), 32'(q1_o[0]), vecs[k].eq1_0);
      chk($sformatf("vec%0d v1_0", k), v1_o[0], vecs[k].ev1_0);
      chk($sformatf("vec%0d q1_1", k), 32'(q1_o[1]), vecs[k].eq1_1);
      chk($sformatf("vec%0d v1_1", k), v1_o[1], vecs[k].ev1_1);
      chk($sformatf("vec%0d q2_1", k), 32'(q2_o[1]), vecs[k].eq2_1);
      chk($sformatf("vec%0d v2_1", k), v2_o[1], vecs[k].ev2_1);
      tick();
    end

    // Snapshot, then overwrite and commit-clear, then restore.
    idle(); dsp_en_i = 2'b01; dsp_rd_i[0] = 1; dsp_tag_i[0] = 3; tick();
    idle(); ckpt_take_i = 1; tick();
    idle(); chk("id after take", 32'(ckpt_id_o), 1);
    dsp_en_i = 2'b01; dsp_rd_i[0] = 1; dsp_tag_i[0] = 5;
    cmt_en_i = 2'b01; cmt_rd_i[0] = 1; cmt_tag_i[0] = 3; cmt_val_i[0] = 32'h77;
    tick();
    idle(); rd_chk("x1 live", 1, 5, 32'h77);
    recover_i = 1; recover_id_i = 0; tick();
    idle();
    rd_chk("x1 recovered", 1, 0, 32'h77);
    rd_chk("x7 recovered", 7, 6, 32'h11);
    chk("id after recover", 32'(ckpt_id_o), 0);
    chk("full after recover", 32'(ckpt_full_o), 0);

    // Fill the bank; lane selection controls which allocs enter the snapshot.
    idle(); ckpt_take_i = 1; ckpt_lane_i = 0; dsp_en_i = 2'b11;
    dsp_rd_i[0] = 12; dsp_tag_i[0] = 1; dsp_rd_i[1] = 13; dsp_tag_i[1] = 2; tick();
    idle(); ckpt_take_i = 1; ckpt_lane_i = 1; dsp_en_i = 2'b11;
    dsp_rd_i[0] = 14; dsp_tag_i[0] = 3; dsp_rd_i[1] = 15; dsp_tag_i[1] = 4; tick();
    idle(); ckpt_take_i = 1; tick();
    idle(); chk("full at 3", 32'(ckpt_full_o), 0);
    ckpt_take_i = 1; tick();
    idle(); chk("full at 4", 32'(ckpt_full_o), 1);
    chk("id wrapped", 32'(ckpt_id_o), 0);
    ckpt_take_i = 1; tick();
    idle(); chk("dropped take full", 32'(ckpt_full_o), 1);
    chk("dropped take id", 32'(ckpt_id_o), 0);

    // Recover slot 1 with a same-cycle commit clear and an ignored alloc.
    recover_i = 1; recover_id_i = 1;
    dsp_en_i = 2'b01; dsp_rd_i[0] = 20; dsp_tag_i[0] = 9;
    cmt_en_i = 2'b01; cmt_rd_i[0] = 7; cmt_tag_i[0] = 6; cmt_val_i[0] = 32'h66;
    tick();
    idle();
    rd_chk("slot1 x15", 15, 4, 0);
    rd_chk("slot1 x20", 20, 0, 0);
    rd_chk("slot1 x7", 7, 0, 32'h66);
    chk("id rec1", 32'(ckpt_id_o), 1);
    chk("full rec1", 32'(ckpt_full_o), 0);
    recover_i = 1; recover_id_i = 0; tick();
    idle();
    rd_chk("slot0 x13", 13, 0, 0);
    rd_chk("slot0 x12", 12, 1, 0);
    rd_chk("slot0 x3", 3, 4, 32'h44);
    chk("id rec0", 32'(ckpt_id_o), 0);

    // Release on an empty bank is ignored.
    ckpt_rel_i = 1; tick();
    take_fill("after empty rel");
    ckpt_rel_i = 1; tick();
    idle(); chk("rel full", 32'(ckpt_full_o), 0);
    chk("rel id", 32'(ckpt_id_o), 0);
    ckpt_take_i = 1; ckpt_rel_i = 1; tick();
    idle(); chk("take+rel full", 32'(ckpt_full_o), 0);
    chk("take+rel id", 32'(ckpt_id_o), 1);
    ckpt_take_i = 1; tick();
    idle(); chk("refill full", 32'(ckpt_full_o), 1);
    chk("refill id", 32'(ckpt_id_o), 2);

    // Flush: Q cleared, V commit still lands, everything else ignored.
    flush_i = 1; ckpt_take_i = 1; recover_i = 1; recover_id_i = 0;
    dsp_en_i = 2'b01; dsp_rd_i[0] = 21; dsp_tag_i[0] = 5;
    cmt_en_i = 2'b01; cmt_rd_i[0] = 12; cmt_tag_i[0] = 9; cmt_val_i[0] = 32'h99;
    tick();
    idle();
    chk("flush full", 32'(ckpt_full_o), 0);
    rd_chk("flush x12", 12, 0, 32'h99);
    rd_chk("flush x21", 21, 0, 0);
    rd_chk("flush x3", 3, 0, 32'h44);
    take_fill("after flush");

    // Release is applied before recover recomputes the count.
    ckpt_rel_i = 1; recover_i = 1; recover_id_i = 3; tick();
    idle();
    chk("rel+rec id", 32'(ckpt_id_o), 3);
    chk("rel+rec full", 32'(ckpt_full_o), 0);
    take_fill("after rel+rec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
